restoring_div16by8: RTL

- Sequential restoring divider; the arithmetic inverse of the pipelined Vedic multiplier chain in the matrix_multiplier datapath.
- Takes a DW-bit dividend and a VW-bit divisor on a start strobe and produces the quotient and remainder after a fixed number of cycles.
- Uses the same start/done handshake as the multiplier blocks, so the two can be chained or swapped in the datapath controller.
- Used for result normalisation and for checking multiplier outputs (product / operand == other operand).

---
 rtl/restoring_div16by8.sv | 96 +++++++++
 1 files changed

// File: rtl/restoring_div16by8.sv
// Sequential restoring divider: one quotient bit per cycle, start/done handshake.
// A zero divisor yields an all-ones quotient and the dividend's low bits as remainder.
module restoring_div16by8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  input  logic          start,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state;
  logic [DW-1:0] d;
  logic [DW-1:0] q;
  logic [VW-1:0] v;
  logic [VW-1:0] lo;
  logic [VW-1:0] r;
  logic [CW-1:0] cnt;

  // r stays below v, so only the trial value needs the extra bit
  logic [VW:0]   t;
  logic [VW-1:0] diff;
  logic          ge;

  always_comb begin
    t    = {r, d[DW-1]};
    ge   = (t >= {1'b0, v});
    diff = t[VW-1:0] - v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      d           <= '0;
      q           <= '0;
      v           <= '0;
      lo          <= '0;
      r           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            d           <= dividend;
            v           <= divisor;
            lo          <= dividend[VW-1:0];
            r           <= '0;
            q           <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= (divisor == '0);
            state       <= RUN;
          end
        end
        RUN: begin
          d   <= {d[DW-2:0], 1'b0};
          q   <= {q[DW-2:0], ge};
          r   <= ge ? diff : t[VW-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) state <= FIN;
        end
        FIN: begin
          if (v == '0) begin
            quotient  <= '1;
            remainder <= lo;
          end else begin
            quotient  <= q;
            remainder <= r;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
